// File: rtl/inst_fetch_queue.sv
// Fetch queue between the byte-serial instruction memory controller and decode.
// Filters tagged responses against the expected PC, buffers {pc, inst} pairs and flushes on redirect.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr_o,
    input  logic        mem_avail_i,
    input  logic [31:0] mem_inst_i,
    input  logic [31:0] mem_addr_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        dec_valid_o,
    output logic [31:0] dec_inst_o,
    output logic [31:0] dec_pc_o,
    input  logic        dec_ready_i,
    output logic        full_o,
    output logic        empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      r_expect_pc;
    logic [31:0]      r_pc_mem   [DEPTH];
    logic [31:0]      r_inst_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_dec_valid;
    logic [31:0]      r_dec_inst;
    logic [31:0]      r_dec_pc;
    logic             r_full;
    logic             r_empty;

    logic             w_pop;
    logic             w_tag_hit;
    logic             w_space;
    logic             w_accept;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [31:0]      w_expect_nxt;
    logic             w_head_new;
    logic [31:0]      w_head_pc_nxt;
    logic [31:0]      w_head_inst_nxt;

    assign mem_addr_o  = r_expect_pc;
    assign dec_valid_o = r_dec_valid;
    assign dec_inst_o  = r_dec_inst;
    assign dec_pc_o    = r_dec_pc;
    assign full_o      = r_full;
    assign empty_o     = r_empty;

    // A full queue still takes a word when the head leaves in the same cycle.
    assign w_pop     = r_dec_valid & dec_ready_i;
    assign w_tag_hit = (mem_addr_i == r_expect_pc);
    assign w_space   = (r_count < DEPTH_C) | w_pop;
    assign w_accept  = mem_avail_i & w_tag_hit & ~jump_i & w_space;

    // Next pointer, count and expected-PC state; a redirect overrides pop and accept.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_expect_nxt = r_expect_pc;
        if (jump_i) begin
            w_rd_ptr_nxt = {PTR_W{1'b0}};
            w_wr_ptr_nxt = {PTR_W{1'b0}};
            w_count_nxt  = {CNT_W{1'b0}};
            w_expect_nxt = jump_addr_i;
        end else begin
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            if (w_accept) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                w_expect_nxt = r_expect_pc + 32'd4;
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
                w_expect_nxt = r_expect_pc;
            end
            case ({w_accept, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Next head entry; the word being written becomes the head when it lands in the head slot.
    always_comb begin
        w_head_new      = w_accept & (w_rd_ptr_nxt == r_wr_ptr);
        w_head_pc_nxt   = 32'h0;
        w_head_inst_nxt = 32'h0;
        if (w_count_nxt == {CNT_W{1'b0}}) begin
            w_head_pc_nxt   = 32'h0;
            w_head_inst_nxt = 32'h0;
        end else if (w_head_new) begin
            w_head_pc_nxt   = mem_addr_i;
            w_head_inst_nxt = mem_inst_i;
        end else begin
            w_head_pc_nxt   = r_pc_mem[w_rd_ptr_nxt];
            w_head_inst_nxt = r_inst_mem[w_rd_ptr_nxt];
        end
    end

    // Entry storage, written at the tail on accept.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_pc_mem[r_wr_ptr]   <= mem_addr_i;
            r_inst_mem[r_wr_ptr] <= mem_inst_i;
        end
    end

    // Control state and registered decode/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_expect_pc <= RESET_PC;
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_dec_valid <= 1'b0;
            r_dec_inst  <= 32'h0;
            r_dec_pc    <= 32'h0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
        end else begin
            r_expect_pc <= w_expect_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
            r_dec_valid <= (w_count_nxt != {CNT_W{1'b0}});
            r_dec_inst  <= w_head_inst_nxt;
            r_dec_pc    <= w_head_pc_nxt;
            r_full      <= (w_count_nxt == DEPTH_C);
            r_empty     <= (w_count_nxt == {CNT_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed plus random bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr_o;
    logic        mem_avail_i;
    logic [31:0] mem_inst_i;
    logic [31:0] mem_addr_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        dec_valid_o;
    logic [31:0] dec_inst_o;
    logic [31:0] dec_pc_o;
    logic        dec_ready_i;
    logic        full_o;
    logic        empty_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_exp;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          fail_cnt = 0;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_addr_o(mem_addr_o),
        .mem_avail_i(mem_avail_i), .mem_inst_i(mem_inst_i), .mem_addr_i(mem_addr_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .dec_valid_o(dec_valid_o), .dec_inst_o(dec_inst_o), .dec_pc_o(dec_pc_o),
        .dec_ready_i(dec_ready_i), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mem_addr", mem_addr_o, m_exp);
        chk("dec_valid", {31'd0, dec_valid_o}, {31'd0, mq.size() > 0});
        chk("full", {31'd0, full_o}, {31'd0, mq.size() == DEPTH});
        chk("empty", {31'd0, empty_o}, {31'd0, mq.size() == 0});
        if (mq.size() > 0) begin
            chk("head_pc", dec_pc_o, mq[0].pc);
            chk("head_inst", dec_inst_o, mq[0].inst);
        end
    endtask

    // One clock: drive inputs, advance the model with the pre-edge view, then compare.
    task automatic step(input logic r, input logic rdy, input logic av, input logic [31:0] tag,
                        input logic [31:0] ins, input logic j, input logic [31:0] ja);
        logic pop;
        logic acc;
        rst = r; dec_ready_i = rdy; mem_avail_i = av; mem_addr_i = tag;
        mem_inst_i = ins; jump_i = j; jump_addr_i = ja;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_exp = 32'h0;
        end else if (j) begin
            mq.delete();
            m_exp = ja;
        end else begin
            pop = (mq.size() > 0) && rdy;
            acc = av && (tag == m_exp) && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{pc: tag, inst: ins});
                m_exp = m_exp + 32'd4;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, rdy, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic resp(input logic rdy, input logic [31:0] tag, input logic [31:0] ins);
        step(1'b0, rdy, 1'b1, tag, ins, 1'b0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] ja);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, ja);
    endtask

    initial begin
        int sel;
        logic [31:0] tag;
        m_exp = 32'h0;

        // Reset values
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rst_inst", dec_inst_o, 32'h0);
        chk("rst_pc", dec_pc_o, 32'h0);

        // In-order stream with decode always ready
        resp(1'b1, 32'h0, 32'h00000013);
        resp(1'b1, 32'h4, 32'h00100093);
        resp(1'b1, 32'h8, 32'h00200113);
        idle(1'b1);
        idle(1'b1);
        chk("stream_end_addr", mem_addr_o, 32'hC);

        // Fill to full, drop the fifth, drain, refetch
        jump(32'h0);
        for (int i = 0; i < 5; i++) resp(1'b0, 32'(i * 4), 32'hA000_0000 + 32'(i));
        chk("full_hold_addr", mem_addr_o, 32'h10);
        for (int i = 0; i < 4; i++) idle(1'b1);
        resp(1'b1, 32'h10, 32'hA000_0004);
        idle(1'b1);

        // Full queue with simultaneous pop and push
        jump(32'h0);
        for (int i = 0; i < 4; i++) resp(1'b0, 32'(i * 4), 32'hB000_0000 + 32'(i));
        resp(1'b1, 32'h10, 32'hB000_0004);
        chk("pop_push_head", dec_pc_o, 32'h4);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Duplicate tag is dropped
        jump(32'h0);
        resp(1'b0, 32'h0, 32'hC000_0000);
        resp(1'b0, 32'h4, 32'hC000_0001);
        resp(1'b0, 32'h4, 32'hC000_0099);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Redirect with a same-cycle response
        jump(32'h0);
        for (int i = 0; i < 3; i++) resp(1'b0, 32'(i * 4), 32'hD000_0000 + 32'(i));
        step(1'b0, 1'b1, 1'b1, 32'hC, 32'hDEAD_BEEF, 1'b1, 32'h100);
        chk("redir_addr", mem_addr_o, 32'h100);
        resp(1'b0, 32'hC, 32'hDEAD_BEEF);
        resp(1'b0, 32'h100, 32'hD000_0100);
        idle(1'b1);
        idle(1'b1);

        // Address wrap, then reset mid-operation
        jump(32'hFFFF_FFFC);
        resp(1'b0, 32'hFFFF_FFFC, 32'hE000_0000);
        chk("wrap_addr", mem_addr_o, 32'h0);
        resp(1'b0, 32'h0, 32'hE000_0001);
        step(1'b1, 1'b0, 1'b1, 32'h4, 32'hE000_0002, 1'b0, 32'h0);
        chk("rst_mid_pc", dec_pc_o, 32'h0);
        chk("rst_mid_inst", dec_inst_o, 32'h0);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6) tag = m_exp;
            else if (sel < 8) tag = m_exp - 32'd4;
            else tag = $urandom;
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 6, tag, $urandom,
                 ($urandom_range(0, 19) == 0), $urandom);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
